// File: rtl/mips_stage_fetch_queue.sv
// mips_stage_fetch_queue
//   Instruction fetch stage with a small in-order instruction queue.
//   Issues sequential fetch requests while credit (queue occupancy plus
//   requests in flight) is below DEPTH. Returned words are queued with
//   their PC and presented to decode. A redirect flushes the queue,
//   restarts fetch at the word-aligned target and drops the responses
//   still owed for requests issued before it.
//
// Ports
//   clock          : rising-edge clock
//   reset_n        : asynchronous active-low reset
//   redirectValid  : branch/jump redirect request
//   redirectAddr   : redirect target (low two bits ignored)
//   imemReq        : fetch request valid
//   imemAddr       : fetch address
//   imemGrant      : memory accepts the request this cycle
//   imemRespValid  : instruction word returned (in order, latency >= 1)
//   imemRespData   : returned instruction word
//   outValid       : queue head valid toward decode
//   outReady       : decode accepts the head
//   outInstr       : head instruction
//   outPc          : head instruction address

module mips_stage_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectAddr,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemGrant,
    input  logic              imemRespValid,
    input  logic [31:0]       imemRespData,
    output logic              outValid,
    input  logic              outReady,
    output logic [31:0]       outInstr,
    output logic [ADDR_W-1:0] outPc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_ALIGN = ~ADDR_W'(3);
    localparam logic [CNT_W:0]    CREDIT   = (CNT_W+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  discard_count;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];

    logic              credit_ok;
    logic              accept;
    logic              resp_live;
    logic              drop;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_pc;

    always_comb begin
        credit_ok   = ({1'b0, occupancy} + {1'b0, inflight}) < CREDIT;
        // Gating with reset_n keeps the request low for the whole reset
        // pulse, not only from the first edge after it.
        imemReq     = reset_n & credit_ok & ~redirectValid;
        imemAddr    = fetch_pc;
        accept      = imemReq & imemGrant;
        // A response with nothing outstanding is a protocol violation and
        // must not disturb any counter.
        resp_live   = imemRespValid & (inflight != '0);
        drop        = resp_live & (discard_count != '0);
        push        = resp_live & ~drop & ~redirectValid;
        pop         = outValid & outReady & ~redirectValid;
        outValid    = (occupancy != '0);
        outInstr    = instr_mem[head];
        outPc       = pc_mem[head];
        redirect_pc = redirectAddr & PC_ALIGN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc      <= RESET_PC;
            resp_pc       <= RESET_PC;
            occupancy     <= '0;
            inflight      <= '0;
            discard_count <= '0;
            head          <= '0;
            tail          <= '0;
        end else begin
            // imemReq is low during a redirect, so accept is 0 there.
            inflight <= inflight + CNT_W'(accept) - CNT_W'(resp_live);
            if (redirectValid) begin
                fetch_pc      <= redirect_pc;
                resp_pc       <= redirect_pc;
                occupancy     <= '0;
                head          <= tail;
                // Every request still owed after this edge predates the
                // redirect; the one answered this cycle is already gone.
                discard_count <= inflight - CNT_W'(resp_live);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (drop) begin
                    discard_count <= discard_count - CNT_W'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                    tail    <= tail + PTR_W'(1);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage is reset so the head reads instruction 0 at RESET_PC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= RESET_PC;
            end
        end else if (push) begin
            instr_mem[tail] <= imemRespData;
            pc_mem[tail]    <= resp_pc;
        end
    end

endmodule
